// File: rtl/uart_matrix_rx.sv
// UART 8N1 receiver that packs four bytes into a 2x2 matrix behind a valid/ready handshake.
// Byte strobe is one clock after the stop-bit sample. matrix_o loads one clock later; a full, unconsumed output drops the new matrix and sets overrun.
module uart_matrix_rx #(
  parameter int CLKS_PER_BIT     = 868,
  parameter int GAP_TIMEOUT_CLKS = 200000
) (
  input  logic        sys_clk_i,
  input  logic        rst_n,
  input  logic        uart_rx_i,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  output logic [31:0] matrix_o,
  output logic        matrix_valid_o,
  input  logic        matrix_ready_i,
  output logic        frame_err_o,
  output logic        overrun_o
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int GW = $clog2(GAP_TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TIMEOUT_CLKS);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t          state, state_nxt;
  logic [1:0]      rst_pipe;
  logic            rst_int_n;
  logic            rx_s1, rx_s2, rx_prev;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            cnt_clr, bit_smp, stop_ok, stop_bad;
  logic [1:0]      slot;
  logic [23:0]     stage;
  logic [GW-1:0]   gap_cnt;
  logic            gap_hit, mat_load;

  // Reset asserts immediately but is released two clocks after rst_n rises.
  always_ff @(posedge sys_clk_i or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_int_n = rst_pipe[1];

  always_ff @(posedge sys_clk_i or negedge rst_int_n) begin
    if (!rst_int_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    bit_smp   = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    unique case (state)
      IDLE: if (rx_prev && !rx_s2) begin
        state_nxt = START;
        cnt_clr   = 1'b1;
      end
      START: if (cnt == HALF_LAST) begin
        cnt_clr   = 1'b1;
        state_nxt = rx_s2 ? IDLE : DATA;
      end
      DATA: if (cnt == BIT_LAST) begin
        cnt_clr = 1'b1;
        bit_smp = 1'b1;
        if (bit_idx == 3'd7) state_nxt = STOP;
      end
      STOP: if (cnt == BIT_LAST) begin
        cnt_clr = 1'b1;
        if (rx_s2) begin
          stop_ok   = 1'b1;
          state_nxt = IDLE;
        end else begin
          stop_bad  = 1'b1;
          state_nxt = WAIT_IDLE;
        end
      end
      WAIT_IDLE: if (rx_s2) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_prev      <= 1'b1;
      cnt          <= '0;
      bit_idx      <= 3'd0;
      shreg        <= 8'd0;
      byte_o       <= 8'd0;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      rx_s1   <= uart_rx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (cnt_clr || state == IDLE || state == WAIT_IDLE) cnt <= '0;
      else                                                cnt <= cnt + 1'b1;
      if (state == IDLE)  bit_idx <= 3'd0;
      else if (bit_smp)   bit_idx <= bit_idx + 3'd1;
      if (bit_smp) shreg <= {rx_s2, shreg[7:1]};
      if (stop_ok) byte_o <= shreg;
      byte_valid_o <= stop_ok;
      frame_err_o  <= stop_bad;
    end
  end

  assign gap_hit  = (gap_cnt == GAP_LAST);
  assign mat_load = byte_valid_o && (slot == 2'd3) && !gap_hit &&
                    (!matrix_valid_o || matrix_ready_i);

  always_ff @(posedge sys_clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      slot           <= 2'd0;
      stage          <= 24'd0;
      gap_cnt        <= '0;
      matrix_o       <= 32'd0;
      matrix_valid_o <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      if (slot != 2'd0 && state == IDLE && !gap_hit) gap_cnt <= gap_cnt + 1'b1;
      else                                           gap_cnt <= '0;

      // A framing error or an over-long gap discards any partial matrix.
      if (frame_err_o || gap_hit) begin
        slot <= 2'd0;
      end else if (byte_valid_o) begin
        slot <= slot + 2'd1;
        case (slot)
          2'd0:    stage[7:0]   <= byte_o;
          2'd1:    stage[15:8]  <= byte_o;
          2'd2:    stage[23:16] <= byte_o;
          default: if (!mat_load) overrun_o <= 1'b1;
        endcase
      end

      if (mat_load) begin
        matrix_o       <= {byte_o, stage};
        matrix_valid_o <= 1'b1;
      end else if (matrix_ready_i) begin
        matrix_valid_o <= 1'b0;
      end
    end
  end

endmodule
